// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared definitions for the elastic pipeline-stage register.
//   - occ_e          : occupancy encodings (EMPTY / BUSY / FULL)
//   - stage bundle   : field widths of the packed inter-stage bundle
//                      (pc, alusel, aluop, operands, offset, wd, wreg)
//   - STAGE_NOP      : the bubble bundle a stage carries when it is empty,
//                      assembled from the legacy EX_NOP / Sel_Nor / NOPAddr /
//                      ZeroWord constants
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    // Occupancy of a stage register; also its state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_BUSY  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Stage bundle field widths.
    localparam int unsigned PC_W     = 32;
    localparam int unsigned ALUSEL_W = 3;
    localparam int unsigned ALUOP_W  = 7;
    localparam int unsigned REG_W    = 32;
    localparam int unsigned OFFSET_W = 16;
    localparam int unsigned WD_W     = 5;
    localparam int unsigned STAGE_W  = PC_W + ALUSEL_W + ALUOP_W + 2 * REG_W
                                     + OFFSET_W + WD_W + 1;

    // Legacy bubble constants.
    localparam logic [ALUOP_W-1:0]  EX_NOP    = '0;
    localparam logic [ALUSEL_W-1:0] SEL_NOR   = '0;
    localparam logic [WD_W-1:0]     NOP_ADDR  = '0;
    localparam logic [REG_W-1:0]    ZERO_WORD = '0;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [ALUSEL_W-1:0] alusel;
        logic [ALUOP_W-1:0]  aluop;
        logic [REG_W-1:0]    reg1;
        logic [REG_W-1:0]    reg2;
        logic [OFFSET_W-1:0] offset;
        logic [WD_W-1:0]     wd;
        logic                wreg;
    } stage_bundle_t;

    // A bubble: no register write, NOP operation, zero operands.
    localparam stage_bundle_t STAGE_NOP = '{
        pc:     ZERO_WORD,
        alusel: SEL_NOR,
        aluop:  EX_NOP,
        reg1:   ZERO_WORD,
        reg2:   ZERO_WORD,
        offset: '0,
        wd:     NOP_ADDR,
        wreg:   1'b0
    };

endpackage

// File: rtl/pipe_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_if
// Handshake bundle around one pipeline-stage register.
//   in_valid / in_ready / in_data    : upstream side
//   out_valid / out_ready / out_data : downstream side
// Modports:
//   slave  : the stage register itself
//   master : whoever drives the stage (upstream producer + downstream consumer)
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both 1. While valid=1 and ready=0 the producer keeps data stable; ready may
// be changed by the consumer at any time and does not depend on anything
// else being asserted first.
// -----------------------------------------------------------------------------
interface pipe_skid_reg_if
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W = STAGE_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline-stage register carrying an opaque DATA_W payload.
//   SKID=1 : two entries (main + skid), in_ready is a flop.
//   SKID=0 : one entry, in_ready = !out_valid | out_ready (combinational).
// Ports:
//   clk          : clock, all state on posedge
//   rst          : synchronous active-high reset, clears everything
//   flush        : synchronous clear of held entries; stall counter kept
//   bus          : pipe_skid_reg_if.slave handshake bundle
//   occupancy    : entries held (0..2), doubles as the state for debug
//   stall_cycles : saturating count of cycles with out_valid & !out_ready
// out_data comes straight from the main register, which holds NOP_VALUE
// whenever the stage is empty.
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W    = STAGE_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter bit                SKID      = 1'b1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_skid_reg_if.slave   bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
);

    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q;
    logic [CNT_W-1:0]  stall_q;

    logic in_ready;
    logic in_fire;
    logic out_fire;

    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid_q & bus.out_ready;

    // Next-state: flush beats every transfer. An out fire in the flush cycle
    // has already been taken by downstream, so dropping it here is correct.
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            occ_d  = OCC_EMPTY;
            main_d = NOP_VALUE;
            skid_d = NOP_VALUE;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_d = bus.in_data;
                        occ_d  = OCC_BUSY;
                    end
                end
                OCC_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (out_fire) begin
                        main_d = NOP_VALUE;
                        occ_d  = OCC_EMPTY;
                    end else if (in_fire && SKID) begin
                        // Downstream stalled while we were still ready:
                        // park the new beat in the skid entry.
                        skid_d = bus.in_data;
                        occ_d  = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        main_d = skid_q;
                        skid_d = NOP_VALUE;
                        occ_d  = OCC_BUSY;
                    end
                end
                default: begin
                    occ_d  = OCC_EMPTY;
                    main_d = NOP_VALUE;
                    skid_d = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            occ_q       <= occ_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= (occ_d != OCC_EMPTY);
            if (out_valid_q && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    generate
        if (SKID) begin : g_skid
            // Registered ready: low only while both entries are held (and
            // for the reset cycle), so upstream never sees a path through
            // out_ready.
            logic in_ready_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (occ_d != OCC_FULL);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready = ~out_valid_q | bus.out_ready;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign occupancy     = occ_q;
    assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Two instances: dut_a (SKID=1) and dut_b (SKID=0), DATA_W=16, NOP=16'hDEAD.
// The reference is a queue of accepted payloads per instance: its size is the
// expected occupancy, its head the expected out_data; ready, stall count and
// flush/reset effects are derived from the handshake rules.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int unsigned W   = 16;
    localparam int unsigned CW  = 16;
    localparam logic [W-1:0] NOP = 16'hDEAD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]    a_occ, b_occ;
    logic [CW-1:0] a_stall, b_stall;

    pipe_skid_reg_if #(.DATA_W(W)) a_if ();
    pipe_skid_reg_if #(.DATA_W(W)) b_if ();

    pipe_skid_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(CW)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_a),
        .bus          (a_if),
        .occupancy    (a_occ),
        .stall_cycles (a_stall)
    );

    pipe_skid_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_W(CW)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_b),
        .bus          (b_if),
        .occupancy    (b_occ),
        .stall_cycles (b_stall)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0]  a_exp_q[$];
    logic [W-1:0]  b_exp_q[$];
    logic [CW-1:0] a_stall_m = '0;
    logic [CW-1:0] b_stall_m = '0;
    bit a_live = 0, b_live = 0, a_rst_prev = 0;
    bit a_stuck = 0, b_stuck = 0;

    always @(negedge clk) begin : mon_a
        logic exp_vld;
        logic exp_rdy;
        exp_vld = (a_exp_q.size() != 0);
        exp_rdy = !a_rst_prev && (a_exp_q.size() < 2);
        if (a_live) begin
            check("a_out_valid", 32'(a_if.out_valid), 32'(exp_vld));
            check("a_out_data", 32'(a_if.out_data), exp_vld ? 32'(a_exp_q[0]) : 32'(NOP));
            check("a_occupancy", 32'(a_occ), 32'(a_exp_q.size()));
            check("a_in_ready", 32'(a_if.in_ready), 32'(exp_rdy));
            check("a_stall_cycles", 32'(a_stall), 32'(a_stall_m));
        end
        a_stuck = a_if.in_valid && !a_if.in_ready;
        if (rst) begin
            a_exp_q.delete();
            a_stall_m  = '0;
            a_rst_prev = 1;
            a_live     = 1;
        end else if (a_live) begin
            a_rst_prev = 0;
            if (exp_vld && !a_if.out_ready && a_stall_m != {CW{1'b1}})
                a_stall_m = a_stall_m + 1'b1;
            if (exp_vld && a_if.out_ready)
                void'(a_exp_q.pop_front());
            if (flush_a)
                a_exp_q.delete();
            else if (a_if.in_valid && exp_rdy)
                a_exp_q.push_back(a_if.in_data);
        end
    end

    always @(negedge clk) begin : mon_b
        logic exp_vld;
        logic exp_rdy;
        exp_vld = (b_exp_q.size() != 0);
        exp_rdy = !exp_vld || b_if.out_ready;
        if (b_live) begin
            check("b_out_valid", 32'(b_if.out_valid), 32'(exp_vld));
            check("b_out_data", 32'(b_if.out_data), exp_vld ? 32'(b_exp_q[0]) : 32'(NOP));
            check("b_occupancy", 32'(b_occ), 32'(b_exp_q.size()));
            check("b_in_ready", 32'(b_if.in_ready), 32'(exp_rdy));
            check("b_stall_cycles", 32'(b_stall), 32'(b_stall_m));
        end
        b_stuck = b_if.in_valid && !b_if.in_ready;
        if (rst) begin
            b_exp_q.delete();
            b_stall_m = '0;
            b_live    = 1;
        end else if (b_live) begin
            if (exp_vld && !b_if.out_ready && b_stall_m != {CW{1'b1}})
                b_stall_m = b_stall_m + 1'b1;
            if (exp_vld && b_if.out_ready)
                void'(b_exp_q.pop_front());
            if (flush_b)
                b_exp_q.delete();
            else if (b_if.in_valid && exp_rdy)
                b_exp_q.push_back(b_if.in_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_if.in_valid  = 1'b0;
        a_if.in_data   = '0;
        a_if.out_ready = 1'b1;
        flush_a        = 1'b0;
    endtask

    task automatic idle_b();
        b_if.in_valid  = 1'b0;
        b_if.in_data   = '0;
        b_if.out_ready = 1'b1;
        flush_b        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_a();
        idle_b();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Random traffic on both instances; a held offer is never changed.
    task automatic rand_cycles(input int n);
        repeat (n) begin
            tick();
            if (!a_stuck) begin
                a_if.in_valid = ($urandom_range(0, 99) < 60);
                a_if.in_data  = 16'($urandom);
            end
            a_if.out_ready = ($urandom_range(0, 99) < 55);
            flush_a        = ($urandom_range(0, 99) < 3);
            if (!b_stuck) begin
                b_if.in_valid = ($urandom_range(0, 99) < 60);
                b_if.in_data  = 16'($urandom);
            end
            b_if.out_ready = ($urandom_range(0, 99) < 55);
            flush_b        = ($urandom_range(0, 99) < 3);
        end
        tick();
        idle_a();
        idle_b();
        repeat (4) tick();
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] stream_v[3];

    initial begin
        idle_a();
        idle_b();
        stream_v[0] = 16'h0011;
        stream_v[1] = 16'h0022;
        stream_v[2] = 16'h0033;

        // Reset and post-reset idle
        do_reset();
        @(negedge clk);
        check("rst_in_ready_low", 32'(a_if.in_ready), 32'd0);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out_data", 32'(a_if.out_data), 32'(NOP));
        check("rst_occupancy", 32'(a_occ), 32'd0);
        check("rst_stall", 32'(a_stall), 32'd0);
        tick();
        @(negedge clk);
        check("rst_in_ready_high", 32'(a_if.in_ready), 32'd1);

        // Back-to-back stream, out_ready=1
        tick();
        a_if.in_valid = 1'b1;
        a_if.in_data  = stream_v[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) a_if.in_data = stream_v[i+1];
            else       a_if.in_valid = 1'b0;
            @(negedge clk);
            check("stream_data", 32'(a_if.out_data), 32'(stream_v[i]));
            check("stream_occ", 32'(a_occ), 32'd1);
        end

        // Skid fill and drain
        do_reset();
        tick();
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 16'h00A1;
        tick();
        a_if.in_data = 16'h00A2;
        tick();
        a_if.in_data = 16'h00A3;
        @(negedge clk);
        check("skid_full_occ", 32'(a_occ), 32'd2);
        check("skid_full_ready", 32'(a_if.in_ready), 32'd0);
        check("skid_full_head", 32'(a_if.out_data), 32'h00A1);
        tick();
        tick();
        a_if.out_ready = 1'b1;
        @(negedge clk);
        check("skid_stall_count", 32'(a_stall), 32'd3);
        check("skid_drain_0", 32'(a_if.out_data), 32'h00A1);
        tick();
        @(negedge clk);
        check("skid_drain_1", 32'(a_if.out_data), 32'h00A2);
        tick();
        a_if.in_valid = 1'b0;
        @(negedge clk);
        check("skid_drain_2", 32'(a_if.out_data), 32'h00A3);
        tick();
        @(negedge clk);
        check("skid_empty_occ", 32'(a_occ), 32'd0);
        check("skid_stall_kept", 32'(a_stall), 32'd3);

        // Flush while FULL with a pending 0xB0
        tick();
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 16'h00C1;
        tick();
        a_if.in_data = 16'h00C2;
        tick();
        a_if.in_data   = 16'h00B0;
        a_if.out_ready = 1'b1;
        flush_a        = 1'b1;
        tick();
        flush_a       = 1'b0;
        a_if.in_valid = 1'b0;
        @(negedge clk);
        check("flush_occ", 32'(a_occ), 32'd0);
        check("flush_out_valid", 32'(a_if.out_valid), 32'd0);
        check("flush_out_data", 32'(a_if.out_data), 32'(NOP));
        check("flush_stall_kept", 32'(a_stall), 32'd4);
        check("flush_in_ready", 32'(a_if.in_ready), 32'd1);
        repeat (4) tick();

        // SKID=0: combinational ready, bubble-free replace
        b_if.in_valid  = 1'b1;
        b_if.in_data   = 16'h00D1;
        b_if.out_ready = 1'b0;
        tick();
        b_if.in_data = 16'h00D2;
        @(negedge clk);
        check("b_ready_stalled", 32'(b_if.in_ready), 32'd0);
        check("b_head_d1", 32'(b_if.out_data), 32'h00D1);
        tick();
        b_if.out_ready = 1'b1;
        @(negedge clk);
        check("b_ready_comb", 32'(b_if.in_ready), 32'd1);
        tick();
        b_if.in_valid = 1'b0;
        @(negedge clk);
        check("b_replace_data", 32'(b_if.out_data), 32'h00D2);
        check("b_replace_occ", 32'(b_occ), 32'd1);
        tick();
        @(negedge clk);
        check("b_drained_occ", 32'(b_occ), 32'd0);

        // Randomised traffic with flushes
        rand_cycles(3000);

        // Stall counter saturation, then reset clears it
        do_reset();
        tick();
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 16'h00E1;
        tick();
        a_if.in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("sat_value", 32'(a_stall), 32'h0000FFFF);
        tick();
        @(negedge clk);
        check("sat_hold", 32'(a_stall), 32'h0000FFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("sat_rst_clear", 32'(a_stall), 32'd0);
        check("sat_rst_occ", 32'(a_occ), 32'd0);
        idle_a();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline-stage register, the successor of the fixed stall/clear stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM).
- Carries an opaque DATA_W-bit payload under valid/ready handshake, with synchronous flush and a NOP payload whenever empty.
- SKID=1 adds a second entry so in_ready is registered, breaking the combinational back-pressure path.
- Saturating stall-cycle counter for performance debug.

Parameters:
DATA_W, 128, payload width in bits (packed stage bundle: pc, alusel, aluop, operands, offset, wd, wreg).
NOP_VALUE, {DATA_W{1'b0}}, payload driven on out_data when the stage is empty, and loaded on reset/flush.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CNT_W, 16, width of stall_cycles counter.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous active-high reset.
flush  in  1  synchronous clear (branch mispredict / exception); drops all held entries.
in_valid  in  1  upstream has a payload.
in_ready  out  1  stage can accept; in fire = in_valid & in_ready.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  stage holds a payload for downstream.
out_ready  in  1  downstream accepts; out fire = out_valid & out_ready.
out_data  out  DATA_W  head payload; NOP_VALUE when out_valid=0.
occupancy  out  2  entries held (0..2; max 1 when SKID=0).
stall_cycles  out  CNT_W  count of cycles with out_valid & !out_ready.

Behaviour:
- State = occupancy: EMPTY(0), BUSY(1), FULL(2, SKID=1 only). Main register feeds out_data; skid register holds the second entry.
- Reset (rst=1):
  - occupancy=0, out_valid=0, main and skid registers=NOP_VALUE, stall_cycles=0.
  - in_ready=0 during the rst cycle when SKID=1, and 1 from the next cycle.
  - Reset mid-transfer discards everything.
- Flush (rst=0, flush=1):
  - Same as reset except stall_cycles is kept.
  - An in fire in the same cycle is dropped; flush wins over all transfers.
  - An out fire in the flush cycle still counts as delivered downstream.
- Transitions (rst=0, flush=0):
  - EMPTY + in fire -> main<=in_data, BUSY.
  - BUSY + in fire + out fire -> main<=in_data, stay BUSY.
  - BUSY + out fire only -> main<=NOP_VALUE, EMPTY.
  - BUSY + in fire only -> SKID=1: skid<=in_data, FULL. (With SKID=0, in_ready=0 here, so this cannot occur.)
  - FULL + out fire -> main<=skid, skid<=NOP_VALUE, BUSY.
  - All other combinations: hold.
- in_ready:
  - SKID=1: registered; equals (occupancy!=2) from the previous state update. 0 while in FULL or the rst cycle.
  - SKID=0: combinational, !out_valid | out_ready (legacy stall semantics).
- Latency and ordering: one-cycle latency; strict FIFO order; no payload is ever duplicated or lost except by flush or rst.
- out_valid = (occupancy!=0), registered. out_data is driven directly from the main register; no combinational path from in_data.
- stall_cycles: +1 each cycle with out_valid & !out_ready; saturates at all-ones. Only rst clears it.
- Upstream must hold in_data stable while in_valid & !in_ready. Downstream may drop out_ready at any time.

Decomposition:
- Shared package (defines.v): occupancy encodings OCC_EMPTY/OCC_BUSY/OCC_FULL, a default stage NOP bundle built from EX_NOP, Sel_Nor, NOPAddr and ZeroWord, and stage bundle width macros.
- Single module, no sub-module. The SKID=0/1 variants are generate branches inside it.

Test Plan:
- Reset hold, then rst=0 with in_valid=0 -> out_valid=0, out_data=NOP_VALUE, occupancy=0, and in_ready=1 one cycle after reset deasserts.
- Stream 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_data shows 0x11,0x22,0x33 on the three cycles after each accept; occupancy stays 1.
- SKID=1: out_ready=0, send 0xA1,0xA2 -> occupancy=2, in_ready=0 and 0xA3 held. Raise out_ready -> outputs 0xA1,0xA2,0xA3 in order, and stall_cycles equals the count of stalled cycles.
- Flush while FULL with in_valid=1 carrying 0xB0 -> next cycle occupancy=0, out_data=NOP_VALUE, 0xB0 never appears; stall_cycles unchanged.
- SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> simultaneous replace with no bubble.
- Hold out_valid=1, out_ready=0 for 70000 cycles with CNT_W=16 -> stall_cycles=0xFFFF and stays there; rst clears it to 0.
